// File: rtl/nco_pkg.sv
// Shared types and constants for the CORDIC phase detector: FSM states,
// datapath widths and the arctangent table in NCO phase units.
package nco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREROT,
        ST_ITER,
        ST_DONE
    } state_e;

    localparam int SAMPLE_W = 16;
    localparam int XY_W     = 18;
    localparam int Z_W      = 16;
    localparam int MAG_W    = 17;
    localparam int CNT_W    = 4;

    // round(atan(2^-n) * 65536 / (2*pi)); entry n sits at index n.
    localparam logic [15:0][Z_W-1:0] ATAN_TABLE = {
        16'd0,    16'd1,    16'd1,    16'd3,
        16'd5,    16'd10,   16'd20,   16'd41,
        16'd81,   16'd163,  16'd326,  16'd651,
        16'd1297, 16'd2555, 16'd4836, 16'd8192
    };

endpackage

// File: rtl/phase_detector.sv
// Iterative CORDIC vectoring phase detector: converts an (I,Q) sample into
// angle, magnitude and phase step relative to the previous result.
module phase_detector
    import nco_pkg::*;
#(
    parameter int ITER = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tick_i,
    input  logic signed [SAMPLE_W-1:0] i_i,
    input  logic signed [SAMPLE_W-1:0] q_i,
    output logic        [Z_W-1:0]      phase_o,
    output logic        [MAG_W-1:0]    mag_o,
    output logic signed [Z_W-1:0]      step_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    state_e                   state_q, state_d;
    logic signed [XY_W-1:0]   x_q, x_d;
    logic signed [XY_W-1:0]   y_q, y_d;
    logic signed [XY_W-1:0]   x_sh, y_sh;
    logic        [Z_W-1:0]    z_q, z_d;
    logic        [Z_W-1:0]    res_z;
    logic        [CNT_W-1:0]  iter_q, iter_d;
    logic                     zero_q, zero_d;
    logic        [Z_W-1:0]    phase_q, phase_d;
    logic        [Z_W-1:0]    prev_q, prev_d;
    logic        [MAG_W-1:0]  mag_q, mag_d;
    logic signed [Z_W-1:0]    step_q, step_d;
    logic                     primed_q, primed_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        iter_d    = iter_q;
        zero_d    = zero_q;
        phase_d   = phase_q;
        prev_d    = prev_q;
        mag_d     = mag_q;
        step_d    = step_q;
        primed_d  = primed_q;
        valid_d   = 1'b0;
        overrun_d = tick_i && (state_q != ST_IDLE);
        x_sh      = x_q >>> iter_q;
        y_sh      = y_q >>> iter_q;
        // A zero vector gives no usable direction; report angle 0 for it.
        res_z     = zero_q ? '0 : z_q;

        case (state_q)
            ST_IDLE: begin
                if (tick_i) begin
                    x_d     = {{(XY_W-SAMPLE_W){i_i[SAMPLE_W-1]}}, i_i};
                    y_d     = {{(XY_W-SAMPLE_W){q_i[SAMPLE_W-1]}}, q_i};
                    state_d = ST_PREROT;
                end
            end
            ST_PREROT: begin
                zero_d = (x_q == '0) && (y_q == '0);
                iter_d = '0;
                // Fold the left half-plane onto the right so iterations converge.
                if (x_q[XY_W-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = 16'h8000;
                end else begin
                    z_d = '0;
                end
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (!y_q[XY_W-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + ATAN_TABLE[iter_q];
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - ATAN_TABLE[iter_q];
                end
                iter_d = iter_q + 1'b1;
                if (iter_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                phase_d  = res_z;
                mag_d    = x_q[MAG_W-1:0];
                step_d   = primed_q ? signed'(res_z - prev_q) : '0;
                prev_d   = res_z;
                primed_d = 1'b1;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            iter_q    <= '0;
            zero_q    <= 1'b0;
            phase_q   <= '0;
            prev_q    <= '0;
            mag_q     <= '0;
            step_q    <= '0;
            primed_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            iter_q    <= iter_d;
            zero_q    <= zero_d;
            phase_q   <= phase_d;
            prev_q    <= prev_d;
            mag_q     <= mag_d;
            step_q    <= step_d;
            primed_q  <= primed_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign phase_o   = phase_q;
    assign mag_o     = mag_q;
    assign step_o    = step_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_phase_detector.sv
// Self-checking bench for phase_detector: an atan2/sqrt reference model with
// cycle-level accept/overrun bookkeeping, plus directed literal checks.
module tb_phase_detector;

    localparam int  ITER = 16;
    localparam real PI   = 3.14159265358979;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick  = 1'b0;
    logic signed [15:0] i_s   = '0;
    logic signed [15:0] q_s   = '0;
    logic        [15:0] phase_o;
    logic        [16:0] mag_o;
    logic signed [15:0] step_o;
    logic               valid_o;
    logic               busy_o;
    logic               overrun_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_valid = 0;
    int cnt_ovr = 0;

    phase_detector #(.ITER(ITER)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tick_i    (tick),
        .i_i       (i_s),
        .q_i       (q_s),
        .phase_o   (phase_o),
        .mag_o     (mag_o),
        .step_o    (step_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic real circ(input real d);
        real r;
        r = d;
        while (r >= 32768.0) r = r - 65536.0;
        while (r < -32768.0) r = r + 65536.0;
        return (r < 0.0) ? -r : r;
    endfunction

    function automatic longint rnd(input real r);
        return (r >= 0.0) ? longint'($rtoi(r + 0.5)) : -longint'($rtoi(-r + 0.5));
    endfunction

    function automatic real ideal_phase(input real ii, input real qq);
        real p;
        p = $atan2(qq, ii) * 65536.0 / (2.0 * PI);
        if (p < 0.0) p = p + 65536.0;
        if (p >= 65536.0) p = p - 65536.0;
        return p;
    endfunction

    function automatic real cordic_gain();
        real g;
        real p;
        g = 1.0;
        p = 1.0;
        for (int n = 0; n < ITER; n++) begin
            g = g * $sqrt(1.0 + p);
            p = p * 0.25;
        end
        return g;
    endfunction

    // Reference model: which ticks are accepted, when results are due, and
    // what they should be, derived from ideal trigonometry.
    int                 cyc = 0;
    int                 done_edge = 0;
    bit                 in_flight = 1'b0;
    bit                 was_busy;
    logic signed [15:0] pend_i, pend_q;
    logic signed [15:0] done_i, done_q;
    bit                 exp_valid = 1'b0;
    bit                 exp_ovr   = 1'b0;
    bit                 exp_busy  = 1'b0;
    bit                 exp_zero  = 1'b0;
    bit                 exp_first = 1'b0;
    real                exp_phase = 0.0;
    real                exp_mag   = 0.0;
    real                exp_step  = 0.0;
    bit                 m_primed  = 1'b0;
    real                m_prev    = 0.0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            in_flight = 1'b0;
            m_primed  = 1'b0;
            m_prev    = 0.0;
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            cyc++;
            was_busy  = in_flight;
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            if (in_flight && cyc == done_edge) begin
                exp_valid = 1'b1;
                in_flight = 1'b0;
                done_i    = pend_i;
                done_q    = pend_q;
                exp_zero  = (pend_i == 0) && (pend_q == 0);
                if (exp_zero) begin
                    exp_phase = 0.0;
                    exp_mag   = 0.0;
                end else begin
                    exp_phase = ideal_phase(real'(pend_i), real'(pend_q));
                    exp_mag   = cordic_gain() * $sqrt(real'(pend_i) * real'(pend_i)
                                                     + real'(pend_q) * real'(pend_q));
                end
                exp_first = !m_primed;
                exp_step  = exp_phase - m_prev;
                m_prev    = exp_phase;
                m_primed  = 1'b1;
            end
            if (tick) begin
                if (was_busy) begin
                    exp_ovr = 1'b1;
                end else begin
                    in_flight = 1'b1;
                    done_edge = cyc + ITER + 2;
                    pend_i    = i_s;
                    pend_q    = q_s;
                end
            end
            exp_busy = in_flight;
        end
    end

    // Per-cycle comparison against the model, half a cycle after each edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_outputs_zero",
                {phase_o, mag_o, step_o, valid_o, busy_o, overrun_o} == '0,
                longint'({phase_o, mag_o, step_o, valid_o, busy_o, overrun_o}), 0);
        end else begin
            chk("valid_o", valid_o == exp_valid, longint'(valid_o), longint'(exp_valid));
            chk("overrun_o", overrun_o == exp_ovr, longint'(overrun_o), longint'(exp_ovr));
            chk("busy_o", busy_o == exp_busy, longint'(busy_o), longint'(exp_busy));
            if (valid_o) cnt_valid++;
            if (overrun_o) cnt_ovr++;
            if (valid_o && exp_valid) begin
                $display("txn i=%0d q=%0d phase=%0d mag=%0d step=%0d (model phase=%0d mag=%0d)",
                         done_i, done_q, phase_o, mag_o, step_o, rnd(exp_phase), rnd(exp_mag));
                if (exp_zero) begin
                    chk("phase_zero_vec", phase_o == 0, longint'(phase_o), 0);
                    chk("mag_zero_vec", mag_o == 0, longint'(mag_o), 0);
                end else begin
                    chk("phase", circ(real'(phase_o) - exp_phase) <= 4.0,
                        longint'(phase_o), rnd(exp_phase));
                    chk("mag", circ(real'(mag_o) - exp_mag) <= 12.0,
                        longint'(mag_o), rnd(exp_mag));
                end
                if (exp_first) begin
                    chk("step_first", step_o == 0, longint'(step_o), 0);
                end else begin
                    chk("step", circ(real'(step_o) - exp_step) <= 8.0,
                        longint'(step_o), rnd(exp_step));
                end
            end
        end
    end

    task automatic pulse_tick(input logic signed [15:0] ii, input logic signed [15:0] qq);
        @(negedge clk);
        i_s  = ii;
        q_s  = qq;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run_one(input logic signed [15:0] ii, input logic signed [15:0] qq,
                           output int lat, output longint ph, output longint mg,
                           output longint st);
        pulse_tick(ii, qq);
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (valid_o) break;
        end
        if (!valid_o) chk("result_timeout", 1'b0, lat, ITER + 2);
        ph = longint'(phase_o);
        mg = longint'(mag_o);
        st = longint'(step_o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int                 lat;
        longint             ph, mg, st;
        int                 v0, o0;
        int                 dir_i  [5];
        int                 dir_q  [5];
        int                 dir_ph [5];
        real                ang, rm;
        logic signed [15:0] ri, rq;
        int                 gap;

        dir_i  = '{0, -32000, 0, -32768, 0};
        dir_q  = '{32000, 0, -32000, -32768, 0};
        dir_ph = '{16384, 32768, 49152, 40960, 0};

        repeat (3) @(negedge clk);
        chk("reset_phase", phase_o == 0, longint'(phase_o), 0);
        chk("reset_busy", busy_o == 1'b0, longint'(busy_o), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Axis and corner vectors with literal expectations.
        run_one(16'sd32000, 16'sd0, lat, ph, mg, st);
        chk("latency_32000_0", lat == 18, lat, 18);
        chk("phase_32000_0", circ(real'(ph)) <= 3.0, ph, 0);
        chk("mag_32000_0", (mg >= 52694) && (mg <= 52702), mg, 52698);
        chk("step_first_after_reset", st == 0, st, 0);
        for (int k = 0; k < 5; k++) begin
            run_one(16'(dir_i[k]), 16'(dir_q[k]), lat, ph, mg, st);
            chk("latency_dir", lat == 18, lat, 18);
            if (k == 4) begin
                chk("phase_zero_literal", ph == 0, ph, 0);
                chk("mag_zero_literal", mg == 0, mg, 0);
            end else begin
                chk("phase_dir", circ(real'(ph) - real'(dir_ph[k])) <= 3.0, ph, dir_ph[k]);
            end
        end

        // Rotating phasor, 13107 per sample, wrapping past 65535.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ang = 2.0 * PI * real'((k * 13107) % 65536) / 65536.0;
            run_one(16'(rnd(30000.0 * $cos(ang))), 16'(rnd(30000.0 * $sin(ang))),
                    lat, ph, mg, st);
            if (k == 0) chk("rot_step_first", st == 0, st, 0);
            else        chk("rot_step", circ(real'(st) - 13107.0) <= 6.0, st, 13107);
            @(negedge clk);
        end

        // Tick five cycles into a computation is dropped.
        v0 = cnt_valid;
        o0 = cnt_ovr;
        pulse_tick(16'sd0, 16'sd20000);
        repeat (3) @(negedge clk);
        pulse_tick(16'sd20000, 16'sd0);
        repeat (30) @(negedge clk);
        chk("busy_tick_overruns", cnt_ovr - o0 == 1, cnt_ovr - o0, 1);
        chk("busy_tick_valids", cnt_valid - v0 == 1, cnt_valid - v0, 1);
        chk("busy_tick_result", circ(real'(phase_o) - 16384.0) <= 3.0, longint'(phase_o), 16384);

        // Tick landing on the DONE->IDLE edge is also an overrun.
        v0 = cnt_valid;
        o0 = cnt_ovr;
        pulse_tick(-16'sd20000, 16'sd0);
        repeat (ITER + 1) @(negedge clk);
        i_s  = 16'sd0;
        q_s  = -16'sd20000;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (25) @(negedge clk);
        chk("done_tick_overruns", cnt_ovr - o0 == 1, cnt_ovr - o0, 1);
        chk("done_tick_valids", cnt_valid - v0 == 1, cnt_valid - v0, 1);
        chk("done_tick_result", circ(real'(phase_o) - 32768.0) <= 3.0, longint'(phase_o), 32768);

        // Asynchronous reset while iteration 7 is in progress.
        v0 = cnt_valid;
        pulse_tick(16'sd0, 16'sd20000);
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_immediate",
            {phase_o, mag_o, step_o, valid_o, busy_o, overrun_o} == '0,
            longint'({phase_o, mag_o, step_o, valid_o, busy_o, overrun_o}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_no_valid", cnt_valid == v0, cnt_valid - v0, 0);
        run_one(-16'sd20000, 16'sd0, lat, ph, mg, st);
        chk("post_reset_latency", lat == 18, lat, 18);
        chk("post_reset_phase", circ(real'(ph) - 32768.0) <= 3.0, ph, 32768);
        chk("post_reset_step", st == 0, st, 0);

        // Random samples at random spacing, some of which collide with busy.
        for (int t = 0; t < 60; t++) begin
            do begin
                ri = 16'($urandom);
                rq = 16'($urandom);
                rm = $sqrt(real'(ri) * real'(ri) + real'(rq) * real'(rq));
            end while (rm < 16384.0);
            pulse_tick(ri, rq);
            gap = $urandom_range(0, 24);
            repeat (gap) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phase_detector.md
PHASE_DETECTOR -- requirements
Module: phase_detector

Interface
REQ-001 SHALL have parameter ITER, default 16, meaning the number of CORDIC vectoring iterations (legal range 8..16).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port tick_i, input, 1 bit: sample strobe; when asserted in IDLE, i_i and q_i are captured.
REQ-005 SHALL have port i_i, input, 16 bits signed: in-phase sample.
REQ-006 SHALL have port q_i, input, 16 bits signed: quadrature sample.
REQ-007 SHALL have port phase_o, output, 16 bits unsigned: measured angle; 0..65535 maps to 0..2π (same scaling as the NCO phase accumulator).
REQ-008 SHALL have port mag_o, output, 17 bits unsigned: vector magnitude including CORDIC gain (about 1.6468).
REQ-009 SHALL have port step_o, output, 16 bits signed: phase_o minus previous phase_o, modulo 2^16 (same units as the NCO step).
REQ-010 SHALL have port valid_o, output, 1 bit: one-cycle pulse when phase_o, mag_o and step_o update.
REQ-011 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when tick_i arrives while busy.

Function
REQ-013 SHALL implement FSM states IDLE, PREROT, ITER, DONE. Transitions: IDLE->PREROT on tick_i; PREROT->ITER; ITER->DONE after ITER cycles; DONE->IDLE.
REQ-014 SHALL, on a tick_i sampled at edge k, update the outputs and assert valid_o for exactly one cycle starting at edge k+ITER+2.
REQ-015 SHALL register x, y as 18-bit signed (sign-extended inputs) and z as 16-bit unsigned; no overflow for any input pair, including -32768.
REQ-016 SHALL, in PREROT: if x<0, set x=-x, y=-y, z=0x8000; otherwise z=0.
REQ-017 SHALL, in iteration n (n=0..ITER-1): if y>=0, x+=y>>>n, y-=x>>>n, z+=ATAN[n]; else the opposite signs; arithmetic shifts; z wraps modulo 2^16.
REQ-018 SHALL use ATAN[n] = round(atan(2^-n)*65536/(2π)), ATAN[0]=8192.
REQ-019 SHALL, in DONE: phase_o=z; mag_o=x[16:0]; step_o=z-prev_phase (wrapping); prev_phase=z.
REQ-020 SHALL force step_o=0 on the first result after reset (unprimed flag), then set primed.
REQ-021 SHALL ignore tick_i while busy_o=1: the sample is dropped, overrun_o pulses, and the in-flight computation is unaffected.
REQ-022 SHALL, for a tick_i in the same cycle DONE->IDLE occurs, treat the tick as overrun (ticks are accepted only in IDLE).
REQ-023 SHALL return phase_o=0 and mag_o=0 for i=q=0.
REQ-024 SHALL achieve phase error of at most ±3 LSB at ITER=16 for |(i,q)| >= 1024.

Reset
REQ-025 SHALL, while rst_ni=0: state=IDLE; phase_o, mag_o, step_o, prev_phase, x, y, z = 0; valid_o, busy_o, overrun_o = 0; primed=0.
REQ-026 SHALL abort any computation on reset assertion mid-operation, produce no valid_o, and after release wait in IDLE for a new tick_i.

Structure
REQ-027 SHALL place the state enum typedef, the ATAN constant table (16 entries x 16 bits) and the internal width constants in shared package nco_pkg.
REQ-028 SHALL be a single module with no sub-module; the vectoring datapath is iterative with one shared add/shift stage.

Verification
REQ-029 SHALL cover: i=32000, q=0 -> phase_o=0±3, mag_o=52698±4, valid_o exactly 18 cycles after tick.
REQ-030 SHALL cover: (0,32000) -> 16384±3; (-32000,0) -> 32768±3; (0,-32000) -> 49152±3; (-32768,-32768) -> 40960±3 with no overflow.
REQ-031 SHALL cover: samples of a cosine/sine pair with phase advancing 13107/sample, one tick every 20 cycles -> first step_o=0, then step_o=13107±3, including across the 65535->0 wrap.
REQ-032 SHALL cover: tick_i 5 cycles after an accepted tick -> overrun_o pulses once, the result matches the first sample, and the second sample produces no valid_o.
REQ-033 SHALL cover: rst_ni low during iteration 7 -> all outputs 0 immediately (asynchronous), no valid_o; after release, a new tick yields a correct result with step_o=0.
